// File: rtl/axi4_lite_ram_slave_pkg.sv
// Shared AXI4-Lite types: response codes, engine states and the byte-address to word-index helper.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Byte offset within a beat is dropped, so unaligned addresses land on the containing word.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input int data_width);
    return (data_width == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage

// File: rtl/axi4_lite_ram_slave_if.sv
// AXI4-Lite bus bundle; master drives addresses, write data and response readies.
interface axi4_lite_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/axi4_lite_ram_slave_be_ram_1r1w.sv
// Simple dual-port RAM: byte-enabled write port, registered read port (1-cycle latency).
// A read and write to the same word on one edge returns the old contents.
module be_ram_1r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SW-1:0]         wstrb,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite RAM target: independent read/write engines, AW/W in any order, SLVERR beyond DEPTH.
// B follows the AW+W edge by one cycle, R follows AR by one cycle; responses hold until ready.
module axi4_lite_ram_slave
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256
) (
  input  logic         clk,
  input  logic         rst,
  axi4_lite_if.slave   bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int RAM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAD        = 64 - ADDR_WIDTH;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  aw_got, w_got, rd_err;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [63:0]           wr_idx, rd_idx;
  logic                  aw_hs, w_hs, ar_hs, aw_have, w_have, wr_commit;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_prot;

  assign aw_hs   = bus.aw_valid && bus.aw_ready;
  assign w_hs    = bus.w_valid && bus.w_ready;
  assign ar_hs   = bus.ar_valid && bus.ar_ready;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;

  // The commit uses whichever half arrives this cycle directly, so B is not delayed by latching.
  assign wr_commit = (wr_state == W_COLLECT) && aw_have && w_have;
  assign wr_addr   = aw_hs ? bus.aw_addr : aw_addr_q;
  assign wr_data   = w_hs ? bus.w_data : w_data_q;
  assign wr_strb   = w_hs ? bus.w_strb : w_strb_q;

  assign wr_idx      = word_index({{PAD{1'b0}}, wr_addr}, DATA_WIDTH);
  assign rd_idx      = word_index({{PAD{1'b0}}, bus.ar_addr}, DATA_WIDTH);
  assign wr_in_range = wr_idx < 64'(DEPTH);
  assign rd_in_range = rd_idx < 64'(DEPTH);

  assign unused_prot = ^{bus.aw_prot, bus.ar_prot};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= W_COLLECT;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      bus.aw_ready <= 1'b0;
      bus.w_ready  <= 1'b0;
      bus.b_valid  <= 1'b0;
      bus.b_resp   <= OKAY;
    end else begin
      case (wr_state)
        W_COLLECT: begin
          if (aw_hs) aw_addr_q <= bus.aw_addr;
          if (w_hs) begin
            w_data_q <= bus.w_data;
            w_strb_q <= bus.w_strb;
          end
          if (wr_commit) begin
            wr_state     <= W_RESP;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            bus.aw_ready <= 1'b0;
            bus.w_ready  <= 1'b0;
            bus.b_valid  <= 1'b1;
            bus.b_resp   <= wr_in_range ? OKAY : SLVERR;
          end else begin
            aw_got       <= aw_have;
            w_got        <= w_have;
            bus.aw_ready <= !aw_have;
            bus.w_ready  <= !w_have;
          end
        end
        W_RESP: begin
          if (bus.b_ready) begin
            wr_state     <= W_COLLECT;
            bus.b_valid  <= 1'b0;
            bus.aw_ready <= 1'b1;
            bus.w_ready  <= 1'b1;
          end
        end
        default: wr_state <= W_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= R_IDLE;
      rd_err       <= 1'b0;
      bus.ar_ready <= 1'b0;
      bus.r_valid  <= 1'b0;
      bus.r_resp   <= OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state     <= R_DATA;
            rd_err       <= !rd_in_range;
            bus.ar_ready <= 1'b0;
            bus.r_valid  <= 1'b1;
            bus.r_resp   <= rd_in_range ? OKAY : SLVERR;
          end else begin
            bus.ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (bus.r_ready) begin
            rd_state     <= R_IDLE;
            bus.r_valid  <= 1'b0;
            bus.ar_ready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // RAM output register holds until the next AR, so data stays stable under backpressure.
  assign bus.r_data = (bus.r_valid && !rd_err) ? ram_rdata : '0;

  be_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_commit && wr_in_range),
    .waddr (wr_idx[RAM_AW-1:0]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (ar_hs),
    .raddr (rd_idx[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Drives a DEPTH=256 and a DEPTH=128 slave with identical traffic and checks both against an array model.
module tb_axi4_lite_ram_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axi4_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus0 ();
  axi4_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus1 ();

  assign bus1.aw_valid = bus0.aw_valid;
  assign bus1.aw_addr  = bus0.aw_addr;
  assign bus1.aw_prot  = bus0.aw_prot;
  assign bus1.w_valid  = bus0.w_valid;
  assign bus1.w_data   = bus0.w_data;
  assign bus1.w_strb   = bus0.w_strb;
  assign bus1.b_ready  = bus0.b_ready;
  assign bus1.ar_valid = bus0.ar_valid;
  assign bus1.ar_addr  = bus0.ar_addr;
  assign bus1.ar_prot  = bus0.ar_prot;
  assign bus1.r_ready  = bus0.r_ready;

  axi4_lite_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(256)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  axi4_lite_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(128)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // Reference memories with per-byte "has been written" flags (RAM is not reset).
  logic [31:0] mem0 [256];
  logic [3:0]  kn0  [256];
  logic [31:0] mem1 [128];
  logic [3:0]  kn1  [128];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic model_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] e0, output logic [1:0] e1);
    int idx;
    idx = int'(addr >> 2);
    e0 = 2'b10;
    e1 = 2'b10;
    if (idx < 256) begin
      e0 = 2'b00;
      for (int b = 0; b < 4; b++)
        if (strb[b]) begin mem0[idx][b*8 +: 8] = data[b*8 +: 8]; kn0[idx][b] = 1'b1; end
    end
    if (idx < 128) begin
      e1 = 2'b00;
      for (int b = 0; b < 4; b++)
        if (strb[b]) begin mem1[idx][b*8 +: 8] = data[b*8 +: 8]; kn1[idx][b] = 1'b1; end
    end
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    logic [1:0] e0, e1;
    for (int t = 0; t < 50 && !(aw_done && w_done); t++) begin
      bus0.aw_valid = !aw_done && (t >= aw_dly);
      bus0.aw_addr  = addr;
      bus0.w_valid  = !w_done && (t >= w_dly);
      bus0.w_data   = data;
      bus0.w_strb   = strb;
      @(negedge clk);
      if (aw_done) chk("aw_ready_held_low", 32'(bus0.aw_ready), 32'd0);
      if (w_done)  chk("w_ready_held_low", 32'(bus0.w_ready), 32'd0);
      if (bus0.aw_valid && bus0.aw_ready) aw_done = 1;
      if (bus0.w_valid && bus0.w_ready) w_done = 1;
      @(posedge clk); #1;
    end
    bus0.aw_valid = 1'b0;
    bus0.w_valid  = 1'b0;
    chk("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
    model_write(addr, data, strb, e0, e1);
    for (int c = 0; c <= b_dly; c++) begin
      bus0.b_ready = (c == b_dly);
      @(negedge clk);
      chk("b_valid0", 32'(bus0.b_valid), 32'd1);
      chk("b_valid1", 32'(bus1.b_valid), 32'd1);
      chk("b_resp0", 32'(bus0.b_resp), 32'(e0));
      chk("b_resp1", 32'(bus1.b_resp), 32'(e1));
      chk("aw_ready_in_resp", 32'(bus0.aw_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus0.b_ready = 1'b0;
    chk("b_valid_dropped", 32'(bus0.b_valid), 32'd0);
    chk("aw_w_ready_back", 32'({bus0.aw_ready, bus0.w_ready}), 32'd3);
  endtask

  task automatic do_read(input logic [9:0] addr, input int ar_dly, input int r_dly, output logic [31:0] got);
    bit done = 0;
    int idx;
    logic [31:0] d0, m0, d1, m1;
    logic [1:0] r0, r1;
    got = '0;
    for (int t = 0; t < 50 && !done; t++) begin
      bus0.ar_valid = (t >= ar_dly);
      bus0.ar_addr  = addr;
      @(negedge clk);
      if (bus0.ar_valid && bus0.ar_ready) begin
        done = 1;
        idx = int'(addr >> 2);
        d0 = mem0[idx]; m0 = lane_mask(kn0[idx]); r0 = 2'b00;
        if (idx < 128) begin d1 = mem1[idx]; m1 = lane_mask(kn1[idx]); r1 = 2'b00; end
        else begin d1 = '0; m1 = '1; r1 = 2'b10; end
      end
      @(posedge clk); #1;
    end
    bus0.ar_valid = 1'b0;
    chk("ar_handshake", 32'(done), 32'd1);
    if (done) begin
      for (int c = 0; c <= r_dly; c++) begin
        bus0.r_ready = (c == r_dly);
        @(negedge clk);
        chk("r_valid0", 32'(bus0.r_valid), 32'd1);
        chk("r_valid1", 32'(bus1.r_valid), 32'd1);
        chk("r_data0", bus0.r_data & m0, d0 & m0);
        chk("r_data1", bus1.r_data & m1, d1 & m1);
        chk("r_resp0", 32'(bus0.r_resp), 32'(r0));
        chk("r_resp1", 32'(bus1.r_resp), 32'(r1));
        chk("ar_ready_in_data", 32'(bus0.ar_ready), 32'd0);
        got = bus0.r_data;
        @(posedge clk); #1;
      end
      bus0.r_ready = 1'b0;
      chk("r_valid_dropped", 32'(bus0.r_valid), 32'd0);
      chk("ar_ready_back", 32'(bus0.ar_ready), 32'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g, g2;
    logic [9:0]  pool [6];
    logic [9:0]  a, a2;
    pool = '{10'h010, 10'h020, 10'h1FC, 10'h200, 10'h204, 10'h3FC};
    for (int i = 0; i < 256; i++) kn0[i] = 4'h0;
    for (int i = 0; i < 128; i++) kn1[i] = 4'h0;
    bus0.aw_valid = 0; bus0.aw_addr = '0; bus0.aw_prot = 3'b000;
    bus0.w_valid = 0; bus0.w_data = '0; bus0.w_strb = '0; bus0.b_ready = 0;
    bus0.ar_valid = 0; bus0.ar_addr = '0; bus0.ar_prot = 3'b000; bus0.r_ready = 0;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valids", 32'({bus0.b_valid, bus0.r_valid, bus1.b_valid, bus1.r_valid}), 32'd0);
      chk("rst_readies", 32'({bus0.aw_ready, bus0.w_ready, bus0.ar_ready}), 32'd0);
      chk("rst_r_data", bus0.r_data, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("readies_before_first_edge", 32'({bus0.aw_ready, bus0.w_ready, bus0.ar_ready}), 32'd0);
    @(posedge clk); #1;
    chk("readies_after_release", 32'({bus0.aw_ready, bus0.w_ready, bus0.ar_ready}), 32'd7);
    chk("resp_after_release", 32'({bus0.b_resp, bus0.r_resp}), 32'd0);

    do_write(10'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(10'h010, 0, 0, g);
    chk("read_deadbeef", g, 32'hDEADBEEF);
    do_write(10'h010, 32'h11223344, 4'b0101, 3, 0, 0);
    do_read(10'h010, 0, 0, g);
    chk("strobe_merge", g, 32'hDE22BE44);
    do_write(10'h3FC, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    do_write(10'h200, 32'hCAFEF00D, 4'hF, 0, 1, 0);
    do_read(10'h200, 0, 0, g);
    do_write(10'h024, 32'h55AA00FF, 4'hF, 1, 0, 5);
    do_read(10'h024, 0, 5, g);
    do_write(10'h024, 32'h12345678, 4'h0, 0, 0, 0);
    do_read(10'h024, 0, 0, g);
    chk("zero_strobe_unchanged", g, 32'h55AA00FF);

    // AW accepted, then reset before W: the orphan address must never produce B.
    bus0.aw_valid = 1'b1; bus0.aw_addr = 10'h030;
    @(posedge clk); #1;
    bus0.aw_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.w_valid = 1'b1; bus0.w_data = 32'hFFFFFFFF; bus0.w_strb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_b_after_reset", 32'(bus0.b_valid), 32'd0);
      @(posedge clk); #1;
      if (bus0.w_ready) bus0.w_valid = 1'b0;
    end
    bus0.w_valid = 1'b0;
    do_write(10'h030, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(10'h030, 0, 0, g);
    chk("fresh_write_after_reset", g, 32'hA5A5A5A5);

    do_write(10'h020, 32'h01010101, 4'hF, 0, 0, 0);
    fork
      do_write(10'h020, 32'h02020202, 4'hF, 0, 0, 0);
      do_read(10'h020, 0, 0, g2);
    join
    chk("collision_old_data", g2, 32'h01010101);
    do_read(10'h020, 0, 0, g);
    chk("after_collision_new_data", g, 32'h02020202);

    for (int it = 0; it < 80; it++) begin
      a  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : (pool[$urandom_range(0, 5)] | 10'($urandom_range(0, 3)));
      a2 = ($urandom_range(0, 1) == 0) ? a : pool[$urandom_range(0, 5)];
      case ($urandom_range(0, 2))
        0: do_write(a, 32'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), g);
        default: fork
          do_write(a, 32'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
          do_read(a2, $urandom_range(0, 2), $urandom_range(0, 2), g2);
        join
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_ram_slave.md
Name: axi4_lite_ram_slave

Overview:
- Parametrised AXI4-Lite slave fronting a byte-writable, word-addressed RAM of DEPTH words.
- Next generation of the team's AXI4-Lite bus block: the bus signals become a working endpoint.
- Adds independent read and write engines, AW/W accepted in any order, write strobes, and SLVERR on out-of-range addresses.
- Sits under the ram/ tree as the memory target for AXI4-Lite masters.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
ADDR_WIDTH, 10, byte address width.
DEPTH, 256, number of DATA_WIDTH words implemented; must satisfy DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
STRB_WIDTH, DATA_WIDTH/8, derived localparam; not overridable.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
aw_valid  in  1  write-address valid
aw_ready  out  1  write-address ready
aw_addr  in  ADDR_WIDTH  write byte address
aw_prot  in  3  protection; ignored
w_valid  in  1  write-data valid
w_ready  out  1  write-data ready
w_data  in  DATA_WIDTH  write data
w_strb  in  STRB_WIDTH  byte-lane enables
b_valid  out  1  write-response valid
b_ready  in  1  write-response ready
b_resp  out  2  write response
ar_valid  in  1  read-address valid
ar_ready  out  1  read-address ready
ar_addr  in  ADDR_WIDTH  read byte address
ar_prot  in  3  protection; ignored
r_valid  out  1  read-data valid
r_ready  in  1  read-data ready
r_data  out  DATA_WIDTH  read data
r_resp  out  2  read response

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: aw_ready, w_ready, ar_ready, b_valid, r_valid = 0; b_resp, r_resp = 2'b00; r_data = 0. RAM contents are not reset.
- Readies: registered; all three rise the first cycle after rst deasserts.
- Word index: addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Low byte-offset bits are ignored (unaligned access treated as aligned). In range iff index < DEPTH.
- Responses: OKAY = 2'b00, SLVERR = 2'b10. Only one transaction outstanding per channel.
- Write FSM, state W_COLLECT:
  - aw_ready=1 until an AW handshake, then address latched and aw_ready=0.
  - w_ready=1 until a W handshake, then data/strb latched and w_ready=0.
  - AW and W may arrive in the same cycle or in either order, any gap.
  - On the edge where both are held, go to W_RESP.
- Write FSM, state W_RESP:
  - The RAM write commits on the entry edge, only lanes with w_strb[i]=1.
  - Out-of-range: no RAM write, b_resp=SLVERR; in range: b_resp=OKAY.
  - b_valid=1 held stable until b_ready. On that handshake edge: b_valid=0, aw_ready=w_ready=1, back to W_COLLECT.
  - w_strb=0 in range: OKAY, memory unchanged.
- Read FSM, state R_IDLE: ar_ready=1. On AR handshake: RAM read, go to R_DATA.
- Read FSM, state R_DATA:
  - ar_ready=0; r_valid=1 the cycle after the AR handshake (latency 1).
  - r_data = stored word, r_resp=OKAY; or r_data=0, r_resp=SLVERR if out of range.
  - r_data/r_resp held stable while r_valid && !r_ready. On the handshake edge return to R_IDLE with ar_ready=1.
  - Back-to-back reads therefore take 2 cycles each.
- Read/write collision: read and write engines run fully concurrently. An AR handshake on the same edge as a write commit to the same word returns the old data (read-before-write). Any later AR returns the new data.
- Reset mid-transaction: rst overrides everything. Latched AW/W are discarded; no B or R response is issued for them; the FSMs return to their reset state.
- Valid-without-ready: the slave never deasserts b_valid or r_valid before the matching handshake.

Decomposition:
- Package axi4_lite_pkg:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
  - wr_state_t {W_COLLECT, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
  - Helper function word_index(addr).
- Sub-module be_ram_1r1w: synchronous RAM, one byte-enabled write port and one registered read port, parameters DATA_WIDTH and DEPTH. No reset on the array.

Test Plan:
- Reset then idle: hold rst 3 cycles, release. All valids 0 during reset; aw_ready=w_ready=ar_ready=1 on the first cycle after release.
- Full write/read: AW addr 0x010 with W 0xDEADBEEF, strb 4'hF, same cycle -> b_valid next cycle, b_resp=00. Then AR 0x010 -> r_valid 1 cycle later, r_data=0xDEADBEEF, r_resp=00.
- Out-of-order and strobes: W 0x11223344 strb 4'b0101 presented 3 cycles before AW 0x010 -> B OKAY. Read 0x010 returns 0xDE22BE44.
- Out of range (DEPTH=256, 32-bit): write to 0x3FC (index 255) -> OKAY. Instantiate DEPTH=128: write 0x200 -> b_resp=10, no RAM change; read 0x200 -> r_data=0, r_resp=10.
- Backpressure: hold b_ready=0 and r_ready=0 for 5 cycles -> b_valid/r_valid, data and resp stable throughout. aw_ready, w_ready, ar_ready stay 0 until the respective handshake.
- Mid-operation reset and collision:
  - AW accepted, then rst pulsed before W -> no B response ever; a fresh write afterwards completes with OKAY.
  - AR to 0x020 on the edge of a write commit to 0x020 -> old data returned; the next read returns new data.
